// File: rtl/led_pkg.sv
// Shared constants for the seven-segment scan decoder:
// segment patterns (gfedcba), digit indices and pattern/enable helpers.
package led_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    localparam logic [1:0] DIG_K1 = 2'd0;
    localparam logic [1:0] DIG_K2 = 2'd1;
    localparam logic [1:0] DIG_K3 = 2'd2;
    localparam logic [1:0] DIG_K4 = 2'd3;

    // Returns {legal, nibble}; legal = 0 for any unlisted pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    // Digit index of a one-hot enable; callers qualify with one-hot check.
    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b0001: return DIG_K1;
            4'b0010: return DIG_K2;
            4'b0100: return DIG_K3;
            4'b1000: return DIG_K4;
            default: return DIG_K1;
        endcase
    endfunction

endpackage

// File: rtl/seg_group_capture.sv
// Dwell tracker and pattern decoder for one 4-digit display group.
// In: clk, rst_n, an[3:0], seg[7:0]. Out: cap_valid/idx/nib/dp/err (1-cycle).
module seg_group_capture
    import led_pkg::*;
#(
    parameter int SETTLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] an,
    input  logic [7:0] seg,
    output logic       cap_valid,
    output logic [1:0] cap_idx,
    output logic [3:0] cap_nib,
    output logic       cap_dp,
    output logic       cap_err
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [11:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          captured_q, captured_d;
    logic          onehot, same, fire;
    logic [4:0]    dec;

    always_comb begin
        onehot     = (an != 4'b0) && ((an & (an - 4'd1)) == 4'b0);
        same       = ({an, seg} == prev_q);
        prev_d     = {an, seg};
        cnt_d      = cnt_q;
        captured_d = captured_q;
        fire       = 1'b0;
        if (!onehot || !same) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else begin
            if (cnt_q != CW'(SETTLE)) begin
                cnt_d = cnt_q + CW'(1);
            end
            // Fire on the cycle the count lands on SETTLE-1, i.e. after
            // SETTLE consecutive identical cycles; captured blocks repeats.
            if ((cnt_d == CW'(SETTLE - 1)) && !captured_q) begin
                fire       = 1'b1;
                captured_d = 1'b1;
            end
        end
        dec = seg_decode(seg[6:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            cnt_q      <= '0;
            captured_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
        end
    end

    assign cap_valid = fire & dec[4];
    assign cap_err   = fire & ~dec[4];
    assign cap_nib   = dec[3:0];
    assign cap_dp    = seg[7];
    assign cap_idx   = an_index(an);

endmodule

// File: rtl/led_scan_decoder.sv
// Rebuilds the 32-bit value and 8 DP bits from two scanned 4-digit groups.
// In: seg0/an0, seg1/an1. Out: num_out, dp_out, frame_valid, decode_err, err_sticky.
module led_scan_decoder
    import led_pkg::*;
#(
    parameter int SETTLE = 16,
    parameter bit SYNC   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg0,
    input  logic [3:0]  an0,
    input  logic [7:0]  seg1,
    input  logic [3:0]  an1,
    output logic [31:0] num_out,
    output logic [7:0]  dp_out,
    output logic        frame_valid,
    output logic        decode_err,
    output logic        err_sticky
);

    logic [23:0] raw, line;

    assign raw = {seg1, an1, seg0, an0};

    generate
        if (SYNC) begin : g_sync
            logic [23:0] meta_q, sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= raw;
                    sync_q <= meta_q;
                end
            end
            assign line = sync_q;
        end else begin : g_direct
            assign line = raw;
        end
    endgenerate

    logic       g0_valid, g0_dp, g0_err;
    logic [1:0] g0_idx;
    logic [3:0] g0_nib;
    logic       g1_valid, g1_dp, g1_err;
    logic [1:0] g1_idx;
    logic [3:0] g1_nib;

    seg_group_capture #(.SETTLE(SETTLE)) u_grp0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (line[3:0]),
        .seg       (line[11:4]),
        .cap_valid (g0_valid),
        .cap_idx   (g0_idx),
        .cap_nib   (g0_nib),
        .cap_dp    (g0_dp),
        .cap_err   (g0_err)
    );

    seg_group_capture #(.SETTLE(SETTLE)) u_grp1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (line[15:12]),
        .seg       (line[23:16]),
        .cap_valid (g1_valid),
        .cap_idx   (g1_idx),
        .cap_nib   (g1_nib),
        .cap_dp    (g1_dp),
        .cap_err   (g1_err)
    );

    logic [31:0] shadow_num_q, shadow_num_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [7:0]  seen_q, seen_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  dp_q, dp_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;
    logic [2:0]  slot0, slot1;

    // K1 is the most significant nibble of a group, so slot = 3 - idx.
    assign slot0 = {1'b0, ~g0_idx};
    assign slot1 = {1'b1, ~g1_idx};

    always_comb begin
        shadow_num_d = shadow_num_q;
        shadow_dp_d  = shadow_dp_q;
        seen_d       = seen_q;
        num_d        = num_q;
        dp_d         = dp_q;
        fv_d         = 1'b0;
        err_d        = g0_err | g1_err;
        sticky_d     = sticky_q | err_d;
        if (g0_valid) begin
            shadow_num_d[{slot0, 2'b00} +: 4] = g0_nib;
            shadow_dp_d[slot0]                = g0_dp;
            seen_d[slot0]                     = 1'b1;
        end
        if (g1_valid) begin
            shadow_num_d[{slot1, 2'b00} +: 4] = g1_nib;
            shadow_dp_d[slot1]                = g1_dp;
            seen_d[slot1]                     = 1'b1;
        end
        // Completion looks at the post-write shadow so simultaneous
        // captures from both groups land in the same frame.
        if (&seen_d) begin
            num_d  = shadow_num_d;
            dp_d   = shadow_dp_d;
            fv_d   = 1'b1;
            seen_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_num_q <= '0;
            shadow_dp_q  <= '0;
            seen_q       <= '0;
            num_q        <= '0;
            dp_q         <= '0;
            fv_q         <= 1'b0;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            shadow_num_q <= shadow_num_d;
            shadow_dp_q  <= shadow_dp_d;
            seen_q       <= seen_d;
            num_q        <= num_d;
            dp_q         <= dp_d;
            fv_q         <= fv_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
        end
    end

    assign num_out     = num_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign decode_err  = err_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder (SETTLE=16, SYNC=1).
// Drives scanned digit patterns and checks rebuilt frames and error flags.
module tb_led_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg0, seg1;
    logic [3:0]  an0, an1;
    logic [31:0] num_out;
    logic [7:0]  dp_out;
    logic        frame_valid, decode_err, err_sticky;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int stray = 0;
    logic [31:0] prev_num = '0;

    led_scan_decoder #(.SETTLE(16), .SYNC(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg0        (seg0),
        .an0         (an0),
        .seg1        (seg1),
        .an1         (an1),
        .num_out     (num_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_num = num_out;
        end else begin
            if (frame_valid) fv_cnt++;
            if (decode_err) err_cnt++;
            if (num_out != prev_num && !frame_valid) stray++;
            prev_num = num_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic show(input logic [3:0] a0, input logic [7:0] s0,
                        input logic [3:0] a1, input logic [7:0] s1,
                        input int n);
        an0 = a0;
        seg0 = s0;
        an1 = a1;
        seg1 = s1;
        repeat (n) @(negedge clk);
    endtask

    // Parallel scan of both groups; skip blanks group 0 at that step,
    // bad replaces group 0's pattern with 0x00 at that step.
    task automatic scan_frame(input logic [31:0] v, input logic [7:0] dp,
                              input int dwell, input int skip, input int bad);
        logic [3:0] a0, a1;
        logic [7:0] s0, s1;
        for (int k = 0; k < 4; k++) begin
            a1 = 4'b0001 << k;
            a0 = (k == skip) ? 4'b0000 : a1;
            s0 = {dp[3-k], enc(v[15-4*k -: 4])};
            if (k == bad) s0 = 8'h00;
            s1 = {dp[7-k], enc(v[31-4*k -: 4])};
            show(a0, s0, a1, s1, dwell);
            show(4'b0, 8'h00, 4'b0, 8'h00, 3);
        end
    endtask

    int fv0, er0;

    initial begin
        rst_n = 1'b0;
        an0 = '0;
        seg0 = '0;
        an1 = '0;
        seg1 = '0;
        repeat (3) @(negedge clk);
        check("rst_num", num_out, 32'h0);
        check("rst_dp", {24'h0, dp_out}, 32'h0);
        check("rst_fv", {31'h0, frame_valid}, 32'h0);
        check("rst_err", {31'h0, decode_err}, 32'h0);
        check("rst_sticky", {31'h0, err_sticky}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, DP off
        fv0 = fv_cnt;
        scan_frame(32'h00BC614E, 8'h00, 64, -1, -1);
        check("f1_cnt", fv_cnt - fv0, 1);
        check("f1_num", num_out, 32'h00BC614E);
        check("f1_dp", {24'h0, dp_out}, 32'h0);

        // DP on digits 0 and 7
        fv0 = fv_cnt;
        scan_frame(32'h00BC614E, 8'h81, 64, -1, -1);
        check("f2_cnt", fv_cnt - fv0, 1);
        check("f2_num", num_out, 32'h00BC614E);
        check("f2_dp", {24'h0, dp_out}, 32'h81);

        // Short dwell on group 0 K4 does not capture
        fv0 = fv_cnt;
        scan_frame(32'h12345678, 8'h00, 64, 3, -1);
        check("short_pre", fv_cnt - fv0, 0);
        show(4'b1000, {1'b0, enc(4'h8)}, 4'b0, 8'h00, 14);
        show(4'b0, 8'h00, 4'b0, 8'h00, 5);
        check("short_cnt", fv_cnt - fv0, 0);
        check("short_num", num_out, 32'h00BC614E);
        show(4'b1000, {1'b0, enc(4'h8)}, 4'b0, 8'h00, 16);
        show(4'b0, 8'h00, 4'b0, 8'h00, 5);
        check("settle_cnt", fv_cnt - fv0, 1);
        check("settle_num", num_out, 32'h12345678);

        // Illegal pattern on group 0 K2
        fv0 = fv_cnt;
        er0 = err_cnt;
        scan_frame(32'hCAFEF00D, 8'h00, 64, -1, 1);
        check("bad_errcnt", err_cnt - er0, 1);
        check("bad_sticky", {31'h0, err_sticky}, 32'h1);
        check("bad_fv", fv_cnt - fv0, 0);
        show(4'b0010, {1'b0, enc(4'h0)}, 4'b0, 8'h00, 64);
        show(4'b0, 8'h00, 4'b0, 8'h00, 3);
        check("fix_fv", fv_cnt - fv0, 1);
        check("fix_num", num_out, 32'hCAFEF00D);
        check("fix_sticky", {31'h0, err_sticky}, 32'h1);

        // Non-one-hot enable is ignored
        fv0 = fv_cnt;
        er0 = err_cnt;
        show(4'b0011, {1'b0, enc(4'h9)}, 4'b0, 8'h00, 100);
        show(4'b0, 8'h00, 4'b0, 8'h00, 3);
        scan_frame(32'h13579BDF, 8'h5A, 64, 0, -1);
        check("multi_fv", fv_cnt - fv0, 0);
        check("multi_err", err_cnt - er0, 0);
        show(4'b0001, 8'hEF, 4'b0, 8'h00, 64);
        show(4'b0, 8'h00, 4'b0, 8'h00, 3);
        check("multi_done", fv_cnt - fv0, 1);
        check("multi_num", num_out, 32'h13579BDF);
        check("multi_dp", {24'h0, dp_out}, 32'h5A);

        // Reset mid-frame discards partial capture
        show(4'b0001, {1'b0, enc(4'h2)}, 4'b0, 8'h00, 64);
        show(4'b0010, {1'b0, enc(4'h2)}, 4'b0, 8'h00, 64);
        show(4'b0100, {1'b0, enc(4'h2)}, 4'b0, 8'h00, 64);
        show(4'b1000, {1'b0, enc(4'h2)}, 4'b0, 8'h00, 64);
        show(4'b0, 8'h00, 4'b0001, {1'b0, enc(4'h1)}, 64);
        show(4'b0, 8'h00, 4'b0, 8'h00, 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_num", num_out, 32'h0);
        check("mid_rst_sticky", {31'h0, err_sticky}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        fv0 = fv_cnt;
        scan_frame(32'hFFFFFFFF, 8'h00, 64, -1, -1);
        check("post_rst_cnt", fv_cnt - fv0, 1);
        check("post_rst_num", num_out, 32'hFFFFFFFF);
        check("post_rst_dp", {24'h0, dp_out}, 32'h0);
        check("stray_num_change", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scan_decoder.md
# led_scan_decoder

Receive-side counterpart of the `led_top` display driver. It watches the scanned seven-segment lines of the two 4-digit display groups, which are either looped back from pins or tapped internally. From those lines it rebuilds the 32-bit hex value and the 8 decimal-point bits being shown. It serves as a self-check monitor for the display path on the board and as a scoreboard source in simulation.

## Interface
Parameters:
- `SETTLE`, default 16: number of consecutive stable cycles a digit must show before it is captured. Minimum 2.
- `SYNC`, default 1: when set to 1, a 2-flop synchroniser is placed on all 24 display inputs. When set to 0, the inputs are used directly.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg0`  in  8  group 0 segments {DP,CG,CF,CE,CD,CC,CB,CA}, active-high.
- `an0`  in  4  group 0 digit enables {K4,K3,K2,K1}, active-high, one-hot when valid.
- `seg1`  in  8  group 1 segments, same bit order as `seg0`.
- `an1`  in  4  group 1 digit enables, same bit order as `an0`.
- `num_out`  out  32  last complete decoded value.
- `dp_out`  out  8  decimal points of the last complete frame; bit i belongs to nibble i.
- `frame_valid`  out  1  1-cycle pulse when `num_out`/`dp_out` are updated.
- `decode_err`  out  1  1-cycle pulse when an illegal segment pattern is captured.
- `err_sticky`  out  1  set by `decode_err`, cleared only by reset.

## Operation
- Digit mapping:
  - Group 1 carries `num[31:16]`: K1 = `[31:28]`, K2 = `[27:24]`, K3 = `[23:20]`, K4 = `[19:16]`.
  - Group 0 carries `num[15:0]`: K1 = `[15:12]` through K4 = `[3:0]`.
- Each group has its own dwell tracker, holding the previous `{an, seg}`, a stable counter and a `captured` flag.
  - If `an` is not one-hot (all zero, or more than one bit set), the counter and `captured` flag clear and nothing is captured.
  - If `{an, seg}` differs from the previous cycle, the counter restarts at 0 and `captured` clears.
  - Otherwise the counter increments and saturates at `SETTLE`.
  - When the counter reaches `SETTLE-1` and `captured` is 0, the digit is captured exactly once and `captured` is set.
- Capture behaviour:
  - `seg[6:0]` is decoded as gfedcba to a nibble: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (all hex).
  - The decoded nibble and `seg[7]` are written into the shadow slot for that digit, and the slot's `seen` bit is set.
  - Any other pattern pulses `decode_err`, sets `err_sticky` and leaves the slot and its `seen` bit untouched.
- Frame completion:
  - When all 8 `seen` bits are 1, the shadow copies to `num_out`/`dp_out`, `frame_valid` pulses and all `seen` bits clear.
  - A slot captured again before the frame completes is overwritten with the newest value.
- Both groups may capture in the same cycle; both writes take effect. If that completes the frame, the copy includes both new values.

## Timing
- Reset: `num_out` = 0, `dp_out` = 0, `frame_valid` = 0, `decode_err` = 0, `err_sticky` = 0. All `seen` bits, counters and shadow slots also reset to 0.
- Latency from a stable input at the block inputs to capture is `SETTLE` cycles, plus 2 cycles when `SYNC` = 1.
- `frame_valid` and `decode_err` are registered and asserted in the cycle after the capture cycle.
- `num_out` changes only in the same cycle that `frame_valid` is high.
- Reset asserted mid-frame discards the partial frame. The first frame after reset needs all 8 digits captured afresh.

## Structure
- Package `led_pkg` holds the 16 segment-pattern constants and the digit-index constants.
- Sub-module `seg_group_capture` is instantiated twice. It contains the dwell tracker and pattern decoder and outputs `cap_valid`, `cap_idx[1:0]`, `cap_nib[3:0]`, `cap_dp` and `cap_err`.
- The top level contains the synchronisers, shadow slots, `seen` mask and output registers.

## Test plan
- Scan `32'h00BC614E` with DP all off, dwell 64 cycles per digit, both groups in parallel → `frame_valid` pulses, `num_out` = 00BC614E, `dp_out` = 00.
- Same value with DP on digits 0 and 7 → `dp_out` = 81.
- Dwell of `SETTLE-2` cycles on one digit → no capture and no `frame_valid`. Raise the dwell to `SETTLE` → frame completes.
- Group 0 K2 shows pattern 0x00 → `decode_err` pulse and `err_sticky` = 1. The frame does not complete until K2 shows a legal pattern.
- `an0` = 4'b0011 held for 100 cycles → no capture. `an0` = 0 (blanking) between digits → no effect on the result.
- `rst_n` low after 5 digits captured, then a full scan of `32'hFFFFFFFF` → exactly one `frame_valid`, `num_out` = FFFFFFFF.
